idex_latch: RTL and testbench
=============================

# idex_latch

Writer side of the ID/EX pipeline boundary. It registers every decode-stage control and data field into the execute-stage copies. It detects load-use hazards and inserts one bubble per hazard, and it applies memory-stall hold and branch/jump flush. Once a halt reaches execute, the block freezes it there. It sits between the decode stage and the execute stage, and it drives the IF/ID hold request.

## Interface
Parameters:
- `CNT_W`, default 32, width of the saturating bubble counter.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `mem_stall`  in  1  memory not ready; the whole register holds.
- `flush`  in  1  branch or jump taken in execute; kills the decode-stage instruction.
- `d_valid`  in  1  the decode-stage fields hold a real instruction.
- `d_uses_rt`  in  1  the decode-stage instruction reads `rt` as a source.
- Decode bundle, inputs, with widths:
  - `d_op` 6, `d_funct` 6, `d_alu_op` 4
  - `d_RdOrRtOr31` 2, `d_pcmode` 2, `d_memOp` 2
  - `d_regWEN`, `d_extType`, `d_immorRt`, `d_iREN`, `d_dREN`, `d_dWEN`, `d_halt`, each 1
  - `d_rs`, `d_rt`, `d_rd`, each 5
  - `d_rdat1`, `d_rdat2`, `d_pc`, each 32
  - `d_imm` 16, `d_jaddr` 26
- Execute bundle `e_*`, outputs: the same names and widths as the decode bundle, registered.
- `e_valid`  out  1  the execute fields hold a real instruction.
- `lu_stall`  out  1  combinational; IF/ID and PC must hold this cycle.
- `halted`  out  1  a halt is latched in execute.
- `bubble_cnt`  out  CNT_W  number of bubbles inserted; saturates.

## Operation
- Bubble: all `e_*` fields and `e_valid` are written to 0.
  - A zero `e_*` word has regWEN, dREN, dWEN, halt and iREN all 0.
- Load destination `ldst`, selected by `e_RdOrRtOr31`:
  - 00 selects `e_rd`.
  - 01 selects `e_rt`.
  - 10 selects 31.
  - 11 selects 0.
- `lu_stall` is asserted when all of the following hold:
  - `e_valid`, `e_dREN` and `d_valid` are 1.
  - `ldst` is not 0.
  - `d_rs` equals `ldst`, or `d_uses_rt` is 1 and `d_rt` equals `ldst`.
- `lu_stall` is forced to 0 when `mem_stall`, `flush` or `halted` is 1.
- Update priority per edge, highest first:
  1. `RST`: bubble; `halted` = 0; `bubble_cnt` = 0.
  2. `halted`: hold all outputs.
  3. `mem_stall`: hold all outputs.
  4. `flush`: bubble.
  5. `lu_stall`: bubble; `bubble_cnt` increments.
  6. `d_valid`: load all `d_*` fields into `e_*`; `e_valid` = 1.
  7. Otherwise: bubble.
- When a load with `d_halt` = 1 occurs, `halted` is set on the same edge. It clears only on `RST`.
- `bubble_cnt` increments only in case 5, and it saturates at all-ones.

## Timing
- Latency: one cycle from decode to execute. A field presented at edge N is visible at `e_*` after edge N.
- Reset values: every `e_*` field, `e_valid`, `halted` and `bubble_cnt` are 0.
  - `lu_stall` resets to 0 as a consequence.
- `lu_stall` lasts one cycle per hazard. After the bubble, `e_valid` = 0, so the held instruction loads on the next edge.
  - Exception: the re-check may re-assert `lu_stall` only if the next execute instruction is a new load.
- `mem_stall` together with `flush` on the same edge: the hold wins, and the flush must be re-presented by the execute stage.
- `flush` together with a load-use condition: a flush bubble is inserted and `bubble_cnt` is unchanged.
- `RST` mid-stall or mid-halt: the next cycle is the reset state, with no residual hazard.
- A halt behind a load-use hazard: bubble first, then the halt loads and `halted` rises on the following edge.

## Test plan
- Reset: assert `RST` with `d_valid` = 1 and `d_halt` = 1.
  - Required: all outputs 0, `halted` = 0.
- Load-use on `rt` destination:
  - Execute holds lw with `e_dREN` = 1, `e_RdOrRtOr31` = 01, `e_rt` = 8. Decode presents `d_rs` = 8.
  - Required: `lu_stall` = 1. Next cycle `e_valid` = 0 and `bubble_cnt` = 1. The cycle after, `e_rs` = 8 and `e_valid` = 1.
- No false hazard:
  - Same load but with `e_rt` = 0, or with `d_uses_rt` = 0 and only `d_rt` = 8 matching.
  - Required: `lu_stall` = 0 and the decode fields load directly.
- Memory stall:
  - `mem_stall` = 1 for 3 cycles while the decode fields change, with `flush` = 1 on the 2nd of those cycles.
  - Required: `e_pc` stays at its prior value, for example 0x40, and `lu_stall` = 0 throughout.
- Flush:
  - `flush` = 1 with `d_valid` = 1, `d_regWEN` = 1, `d_pc` = 0x100.
  - Required: `e_valid` = 0, `e_regWEN` = 0, `e_pc` = 0, and `bubble_cnt` unchanged.
- Halt freeze:
  - Load an instruction with `d_halt` = 1, `d_pc` = 0x200, then keep presenting new decode fields.
  - Required: `halted` = 1, `e_pc` holds 0x200 indefinitely, and `halted` clears only after `RST`.

Source files
------------

// File: rtl/idex_latch.sv
// ID/EX pipeline register with load-use bubble insertion, memory-stall hold,
// branch/jump flush and halt freeze.
module idex_latch #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic             d_valid,
  input  logic             d_uses_rt,
  input  logic [5:0]       d_op,
  input  logic [5:0]       d_funct,
  input  logic [3:0]       d_alu_op,
  input  logic [1:0]       d_RdOrRtOr31,
  input  logic [1:0]       d_pcmode,
  input  logic [1:0]       d_memOp,
  input  logic             d_regWEN,
  input  logic             d_extType,
  input  logic             d_immorRt,
  input  logic             d_iREN,
  input  logic             d_dREN,
  input  logic             d_dWEN,
  input  logic             d_halt,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [4:0]       d_rd,
  input  logic [31:0]      d_rdat1,
  input  logic [31:0]      d_rdat2,
  input  logic [31:0]      d_pc,
  input  logic [15:0]      d_imm,
  input  logic [25:0]      d_jaddr,
  output logic [5:0]       e_op,
  output logic [5:0]       e_funct,
  output logic [3:0]       e_alu_op,
  output logic [1:0]       e_RdOrRtOr31,
  output logic [1:0]       e_pcmode,
  output logic [1:0]       e_memOp,
  output logic             e_regWEN,
  output logic             e_extType,
  output logic             e_immorRt,
  output logic             e_iREN,
  output logic             e_dREN,
  output logic             e_dWEN,
  output logic             e_halt,
  output logic [4:0]       e_rs,
  output logic [4:0]       e_rt,
  output logic [4:0]       e_rd,
  output logic [31:0]      e_rdat1,
  output logic [31:0]      e_rdat2,
  output logic [31:0]      e_pc,
  output logic [15:0]      e_imm,
  output logic [25:0]      e_jaddr,
  output logic             e_valid,
  output logic             lu_stall,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int BW = 182;

  // The whole bundle is handled as one word so a bubble is a single clear.
  logic [BW-1:0] d_word;
  logic [BW-1:0] e_word;
  logic [4:0]    ldst;
  logic          hazard;

  assign d_word = {d_op, d_funct, d_alu_op, d_RdOrRtOr31, d_pcmode, d_memOp,
                   d_regWEN, d_extType, d_immorRt, d_iREN, d_dREN, d_dWEN, d_halt,
                   d_rs, d_rt, d_rd, d_rdat1, d_rdat2, d_pc, d_imm, d_jaddr};

  assign {e_op, e_funct, e_alu_op, e_RdOrRtOr31, e_pcmode, e_memOp,
          e_regWEN, e_extType, e_immorRt, e_iREN, e_dREN, e_dWEN, e_halt,
          e_rs, e_rt, e_rd, e_rdat1, e_rdat2, e_pc, e_imm, e_jaddr} = e_word;

  always_comb begin
    ldst = 5'd0;
    case (e_RdOrRtOr31)
      2'b00:   ldst = e_rd;
      2'b01:   ldst = e_rt;
      2'b10:   ldst = 5'd31;
      default: ldst = 5'd0;
    endcase
  end

  assign hazard = e_valid && e_dREN && d_valid && (ldst != 5'd0) &&
                  ((d_rs == ldst) || (d_uses_rt && (d_rt == ldst)));

  // Any hold or flush already covers the hazard, so no stall is requested.
  assign lu_stall = hazard && !mem_stall && !flush && !halted;

  always_ff @(posedge CLK) begin
    if (RST) begin
      e_word     <= '0;
      e_valid    <= 1'b0;
      halted     <= 1'b0;
      bubble_cnt <= '0;
    end else if (!halted && !mem_stall) begin
      if (flush) begin
        e_word  <= '0;
        e_valid <= 1'b0;
      end else if (lu_stall) begin
        e_word  <= '0;
        e_valid <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (d_valid) begin
        e_word  <= d_word;
        e_valid <= 1'b1;
        if (d_halt) halted <= 1'b1;
      end else begin
        e_word  <= '0;
        e_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idex_latch.sv
// Bench for idex_latch: directed vector table followed by random stimulus
// checked against a behavioural model of the pipeline boundary.
module tb_idex_latch;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  alu_op;
    logic [1:0]  sel;
    logic [1:0]  pcmode;
    logic [1:0]  memop;
    logic        regwen;
    logic        extt;
    logic        immrt;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic        halt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [25:0] jaddr;
  } dec_t;

  typedef struct {
    logic rst, ms, fl, dv, urt;
    logic [4:0] rs, rt;
    logic [1:0] sel;
    logic dren, halt;
    logic [31:0] pc;
    logic xlu, xev;
    logic [31:0] xpc;
    logic [4:0] xrs;
    logic xhalt;
    logic [CW-1:0] xcnt;
  } vec_t;

  logic CLK = 1'b0;
  logic RST, mem_stall, flush, d_valid, d_uses_rt;
  dec_t d;
  dec_t e_obs;

  logic [5:0] e_op, e_funct;
  logic [3:0] e_alu_op;
  logic [1:0] e_RdOrRtOr31, e_pcmode, e_memOp;
  logic e_regWEN, e_extType, e_immorRt, e_iREN, e_dREN, e_dWEN, e_halt;
  logic [4:0] e_rs, e_rt, e_rd;
  logic [31:0] e_rdat1, e_rdat2, e_pc;
  logic [15:0] e_imm;
  logic [25:0] e_jaddr;
  logic e_valid, lu_stall, halted;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  idex_latch #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .mem_stall(mem_stall), .flush(flush),
    .d_valid(d_valid), .d_uses_rt(d_uses_rt),
    .d_op(d.op), .d_funct(d.funct), .d_alu_op(d.alu_op),
    .d_RdOrRtOr31(d.sel), .d_pcmode(d.pcmode), .d_memOp(d.memop),
    .d_regWEN(d.regwen), .d_extType(d.extt), .d_immorRt(d.immrt),
    .d_iREN(d.iren), .d_dREN(d.dren), .d_dWEN(d.dwen), .d_halt(d.halt),
    .d_rs(d.rs), .d_rt(d.rt), .d_rd(d.rd),
    .d_rdat1(d.rdat1), .d_rdat2(d.rdat2), .d_pc(d.pc),
    .d_imm(d.imm), .d_jaddr(d.jaddr),
    .e_op(e_op), .e_funct(e_funct), .e_alu_op(e_alu_op),
    .e_RdOrRtOr31(e_RdOrRtOr31), .e_pcmode(e_pcmode), .e_memOp(e_memOp),
    .e_regWEN(e_regWEN), .e_extType(e_extType), .e_immorRt(e_immorRt),
    .e_iREN(e_iREN), .e_dREN(e_dREN), .e_dWEN(e_dWEN), .e_halt(e_halt),
    .e_rs(e_rs), .e_rt(e_rt), .e_rd(e_rd),
    .e_rdat1(e_rdat1), .e_rdat2(e_rdat2), .e_pc(e_pc),
    .e_imm(e_imm), .e_jaddr(e_jaddr),
    .e_valid(e_valid), .lu_stall(lu_stall), .halted(halted),
    .bubble_cnt(bubble_cnt)
  );

  assign e_obs = {e_op, e_funct, e_alu_op, e_RdOrRtOr31, e_pcmode, e_memOp,
                  e_regWEN, e_extType, e_immorRt, e_iREN, e_dREN, e_dWEN, e_halt,
                  e_rs, e_rt, e_rd, e_rdat1, e_rdat2, e_pc, e_imm, e_jaddr};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, ms, fl, dv, urt,
                              input logic [4:0] rs, rt, input logic [1:0] sel,
                              input logic dren, halt, input logic [31:0] pc,
                              input logic xlu, xev, input logic [31:0] xpc,
                              input logic [4:0] xrs, input logic xhalt,
                              input logic [CW-1:0] xcnt);
    vec_t v;
    v.rst = rst; v.ms = ms; v.fl = fl; v.dv = dv; v.urt = urt;
    v.rs = rs; v.rt = rt; v.sel = sel; v.dren = dren; v.halt = halt; v.pc = pc;
    v.xlu = xlu; v.xev = xev; v.xpc = xpc; v.xrs = xrs; v.xhalt = xhalt; v.xcnt = xcnt;
    return v;
  endfunction

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  vec_t tbl[$];

  // reference model state
  dec_t m_e;
  logic m_v, m_halt;
  int   m_bubbles;

  initial begin
    logic [191:0] r;
    logic [4:0] dest_of_sel[4];
    logic [4:0] ldst;
    logic exp_lu;

    RST = 1'b1; mem_stall = 1'b0; flush = 1'b0; d_valid = 1'b0; d_uses_rt = 1'b0;
    d = '0;

    //          rst ms fl dv urt rs rt sel dren halt pc      | lu ev pc      rs halt cnt
    tbl.push_back(mk(1,0,0,1,0, 0, 0,2'd0,0,1,32'h10,  0,0,32'h0,  0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1, 8,2'd1,1,0,32'h40,  0,1,32'h40, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 8, 3,2'd0,0,0,32'h44,  1,0,32'h0,  0,0,1));
    tbl.push_back(mk(0,0,0,1,0, 8, 3,2'd0,0,0,32'h44,  0,1,32'h44, 8,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2, 0,2'd1,1,0,32'h48,  0,1,32'h48, 2,0,1));
    tbl.push_back(mk(0,0,0,1,1, 0, 0,2'd0,0,0,32'h4c,  0,1,32'h4c, 0,0,1));
    tbl.push_back(mk(0,0,0,1,0, 3, 8,2'd1,1,0,32'h50,  0,1,32'h50, 3,0,1));
    tbl.push_back(mk(0,0,0,1,0, 4, 8,2'd0,0,0,32'h54,  0,1,32'h54, 4,0,1));
    tbl.push_back(mk(0,0,0,1,0, 5, 5,2'd1,1,0,32'h40,  0,1,32'h40, 5,0,1));
    tbl.push_back(mk(0,1,0,1,1, 5, 5,2'd0,0,0,32'h60,  0,1,32'h40, 5,0,1));
    tbl.push_back(mk(0,1,1,1,1, 5, 5,2'd0,0,0,32'h64,  0,1,32'h40, 5,0,1));
    tbl.push_back(mk(0,1,0,1,1, 5, 5,2'd0,0,0,32'h68,  0,1,32'h40, 5,0,1));
    tbl.push_back(mk(0,0,0,1,0, 5, 0,2'd0,0,0,32'h6c,  1,0,32'h0,  0,0,2));
    tbl.push_back(mk(0,0,1,1,0, 9, 0,2'd0,0,0,32'h100, 0,0,32'h0,  0,0,2));
    tbl.push_back(mk(0,0,0,1,0, 1, 7,2'd1,1,0,32'h70,  0,1,32'h70, 1,0,2));
    tbl.push_back(mk(0,0,1,1,0, 7, 0,2'd0,0,0,32'h74,  0,0,32'h0,  0,0,2));
    tbl.push_back(mk(0,0,0,1,0, 2, 9,2'd1,1,0,32'h80,  0,1,32'h80, 2,0,2));
    tbl.push_back(mk(0,0,0,1,0, 9, 0,2'd0,0,1,32'h200, 1,0,32'h0,  0,0,3));
    tbl.push_back(mk(0,0,0,1,0, 9, 0,2'd0,0,1,32'h200, 0,1,32'h200,9,1,3));
    tbl.push_back(mk(0,0,0,1,0, 3, 0,2'd0,0,0,32'h300, 0,1,32'h200,9,1,3));
    tbl.push_back(mk(0,1,0,1,0, 3, 0,2'd0,0,0,32'h304, 0,1,32'h200,9,1,3));
    tbl.push_back(mk(1,0,0,0,0, 0, 0,2'd0,0,0,32'h0,   0,0,32'h0,  0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1, 0,2'd2,1,0,32'h90,  0,1,32'h90, 1,0,0));
    tbl.push_back(mk(0,0,0,1,1, 2,31,2'd0,0,0,32'h94,  1,0,32'h0,  0,0,1));
    tbl.push_back(mk(0,0,0,1,1, 2,31,2'd0,0,0,32'h94,  0,1,32'h94, 2,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0, 0,2'd0,0,0,32'h0,   0,0,32'h0,  0,0,0));

    repeat (2) @(posedge CLK);

    foreach (tbl[i]) begin
      @(negedge CLK);
      RST = tbl[i].rst; mem_stall = tbl[i].ms; flush = tbl[i].fl;
      d_valid = tbl[i].dv; d_uses_rt = tbl[i].urt;
      d = '0;
      d.rs = tbl[i].rs; d.rt = tbl[i].rt; d.sel = tbl[i].sel;
      d.dren = tbl[i].dren; d.halt = tbl[i].halt; d.pc = tbl[i].pc;
      d.regwen = tbl[i].dv;
      #1;
      chk($sformatf("row%0d lu_stall", i), 256'(lu_stall), 256'(tbl[i].xlu));
      @(posedge CLK); #1;
      chk($sformatf("row%0d e_valid", i), 256'(e_valid), 256'(tbl[i].xev));
      chk($sformatf("row%0d e_pc", i), 256'(e_pc), 256'(tbl[i].xpc));
      chk($sformatf("row%0d e_rs", i), 256'(e_rs), 256'(tbl[i].xrs));
      chk($sformatf("row%0d e_regWEN", i), 256'(e_regWEN), 256'(tbl[i].xev));
      chk($sformatf("row%0d halted", i), 256'(halted), 256'(tbl[i].xhalt));
      chk($sformatf("row%0d bubble_cnt", i), 256'(bubble_cnt), 256'(tbl[i].xcnt));
    end

    // random phase; the table ends in reset so the model starts from zero
    m_e = '0; m_v = 1'b0; m_halt = 1'b0; m_bubbles = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      d = r[181:0];
      d.rs = pick_reg(); d.rt = pick_reg(); d.rd = pick_reg();
      d.halt = ($urandom_range(0, 29) == 0);
      RST       = ($urandom_range(0, 39) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      d_valid   = ($urandom_range(0, 3) != 0);
      d_uses_rt = 1'($urandom());
      #1;
      dest_of_sel[0] = m_e.rd;
      dest_of_sel[1] = m_e.rt;
      dest_of_sel[2] = 5'd31;
      dest_of_sel[3] = 5'd0;
      ldst = dest_of_sel[m_e.sel];
      exp_lu = m_v && m_e.dren && d_valid && ldst != 0 &&
               (d.rs == ldst || (d_uses_rt && d.rt == ldst)) &&
               !mem_stall && !flush && !m_halt;
      chk($sformatf("rnd%0d lu_stall", cyc), 256'(lu_stall), 256'(exp_lu));
      @(posedge CLK); #1;
      if (RST) begin
        m_e = '0; m_v = 1'b0; m_halt = 1'b0; m_bubbles = 0;
      end else if (m_halt || mem_stall) begin
        // register frozen
      end else if (!flush && !exp_lu && d_valid) begin
        m_e = d; m_v = 1'b1;
        if (d.halt) m_halt = 1'b1;
      end else begin
        m_e = '0; m_v = 1'b0;
        if (exp_lu) m_bubbles++;
      end
      chk($sformatf("rnd%0d e_bundle", cyc), 256'(e_obs), 256'(m_e));
      chk($sformatf("rnd%0d e_valid", cyc), 256'(e_valid), 256'(m_v));
      chk($sformatf("rnd%0d halted", cyc), 256'(halted), 256'(m_halt));
      chk($sformatf("rnd%0d bubble_cnt", cyc), 256'(bubble_cnt),
          256'((m_bubbles > CMAX) ? CMAX : m_bubbles));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
